// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder
//   Measures an RC-servo PWM input. Reports the accepted high time (pos) in
//   clock cycles and the rising-to-rising frame period, and flags loss of
//   signal when no rising edge arrives for TMO cycles.
//
//   Optional build macro: SERVO_DEC_DEGLITCH_EN adds a 3-sample stability
//   filter after the synchronizer. Pulses or gaps shorter than 3 cycles are
//   swallowed, and edge latency grows from 3 to 6 cycles.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   pwm_in    asynchronous servo pulse input
//   pos       last accepted high time, in cycles (N bits)
//   pos_valid one-cycle strobe, high in the cycle pos updates
//   period    last rising-to-rising interval, in cycles (NP bits)
//   lost      no valid frame within TMO cycles; high out of reset
module servo_pulse_decoder #(
  parameter int N     = 18,
  parameter int NP    = 20,
  parameter int MIN_W = 6000,
  parameter int MAX_W = 30000,
  parameter int TMO   = 360000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [N-1:0]  pos,
  output logic          pos_valid,
  output logic [NP-1:0] period,
  output logic          lost
);

  localparam logic [N-1:0]  MIN_V  = N'(MIN_W);
  localparam logic [N-1:0]  MAX_V  = N'(MAX_W);
  localparam logic [N-1:0]  W_SAT  = '1;
  localparam logic [NP-1:0] P_SAT  = '1;
  localparam logic [NP-1:0] TMO_V  = NP'(TMO);
  // The synchronizer and the filter reset low, so a low s_in right after
  // reset says nothing about the pin. SYNC waits this many cycles so the
  // whole input pipeline holds real samples before it trusts a low level.
  localparam logic [2:0]    SETTLE = 3'd7;

  typedef enum logic [1:0] {SYNC, WAIT_RISE, HIGH, LOW} state_t;

  // ---------------------------------------------------------------------
  // Input synchronizer and edge detect
  // ---------------------------------------------------------------------
  logic s1, s2, s_in, s_d;
  logic rise, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef SERVO_DEC_DEGLITCH_EN
  // s_f follows s2 only after s2 has disagreed with it for 3 straight
  // cycles; any return to agreement restarts the count.
  logic       s_f;
  logic [1:0] dg_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_f    <= 1'b0;
      dg_cnt <= 2'd0;
    end else if (s2 == s_f) begin
      dg_cnt <= 2'd0;
    end else if (dg_cnt == 2'd2) begin
      s_f    <= s2;
      dg_cnt <= 2'd0;
    end else begin
      dg_cnt <= dg_cnt + 2'd1;
    end
  end

  assign s_in = s_f;
`else
  assign s_in = s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s_in;
  end

  assign rise = s_in & ~s_d;
  assign fall = ~s_in & s_d;

  // ---------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------
  state_t          state, state_n;
  logic [2:0]      sync_cnt, sync_cnt_n;
  logic [N-1:0]    width, width_n;
  logic [NP-1:0]   per, per_n;
  logic [N-1:0]    pos_n;
  logic            pos_valid_n;
  logic [NP-1:0]   period_n;
  logic            lost_n;
  logic            tmo_hit;
  logic            w_ok;

  assign tmo_hit = (per == TMO_V);
  // A saturated counter means the true width is unknown, so reject it even
  // if MAX_W happens to reach the saturation value.
  assign w_ok    = (width >= MIN_V) && (width <= MAX_V) && (width != W_SAT);

  always_comb begin
    state_n     = state;
    sync_cnt_n  = sync_cnt;
    width_n     = width;
    per_n       = per;
    pos_n       = pos;
    pos_valid_n = 1'b0;
    period_n    = period;
    lost_n      = lost;

    case (state)
      SYNC: begin
        if (sync_cnt != SETTLE) sync_cnt_n = sync_cnt + 3'd1;
        else if (!s_in)         state_n    = WAIT_RISE;
      end

      WAIT_RISE: begin
        if (rise) begin
          width_n = {{(N-1){1'b0}}, 1'b1};
          per_n   = {{(NP-1){1'b0}}, 1'b1};
          state_n = HIGH;
        end
      end

      HIGH: begin
        per_n   = (per == P_SAT) ? per : per + 1'b1;
        width_n = (width == W_SAT) ? width : width + 1'b1;
        if (tmo_hit) begin
          lost_n  = 1'b1;
          state_n = WAIT_RISE;
        end else if (fall) begin
          if (w_ok) begin
            pos_n       = width;
            pos_valid_n = 1'b1;
            lost_n      = 1'b0;
          end
          state_n = LOW;
        end
      end

      LOW: begin
        per_n = (per == P_SAT) ? per : per + 1'b1;
        if (tmo_hit) begin
          lost_n  = 1'b1;
          state_n = WAIT_RISE;
        end else if (rise) begin
          period_n = per;
          width_n  = {{(N-1){1'b0}}, 1'b1};
          per_n    = {{(NP-1){1'b0}}, 1'b1};
          state_n  = HIGH;
        end
      end

      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      sync_cnt  <= 3'd0;
      width     <= '0;
      per       <= '0;
      pos       <= '0;
      pos_valid <= 1'b0;
      period    <= '0;
      lost      <= 1'b1;
    end else begin
      state     <= state_n;
      sync_cnt  <= sync_cnt_n;
      width     <= width_n;
      per       <= per_n;
      pos       <= pos_n;
      pos_valid <= pos_valid_n;
      period    <= period_n;
      lost      <= lost_n;
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// tb_servo_pulse_decoder
//   Directed stimulus against a scaled-down decoder (short widths and
//   timeout) with an event-time model: widths and periods are differences
//   of the cycle numbers at which the delayed input level changes.
module tb_servo_pulse_decoder;

  localparam int N     = 10;
  localparam int NP    = 12;
  localparam int MIN_W = 60;
  localparam int MAX_W = 1000;
  localparam int TMO   = 3600;
  localparam int WSAT  = (1 << N) - 1;
`ifdef SERVO_DEC_DEGLITCH_EN
  localparam int LAT = 6;
  localparam bit DG  = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DG  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_in;
  logic [N-1:0]  pos;
  logic          pos_valid;
  logic [NP-1:0] period;
  logic          lost;

  servo_pulse_decoder #(.N(N), .NP(NP), .MIN_W(MIN_W), .MAX_W(MAX_W), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .pos       (pos),
    .pos_valid (pos_valid),
    .period    (period),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model: mode 0 = waiting for a trusted low, 1 = idle, 2 = in pulse,
  // 3 = between pulses. The level it acts on is the pin sampled LAT-1
  // edges ago (or the 3-sample-stable version of it when filtered).
  // ---------------------------------------------------------------------
  bit hist [0:5];
  int real_cnt, mmode, t_rise, e_pos, e_period, w;
  bit flvl, lvl, lprev, e_lost, e_valid, m_rise, m_fall, prev_lost;
  int nvalid = 0, last_valid_cyc = 0, lost_rise_cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int k = 0; k < 6; k++) hist[k] = 1'b0;
      real_cnt = 0; flvl = 1'b0; lprev = 1'b0; mmode = 0; t_rise = 0;
      e_pos = 0; e_period = 0; e_lost = 1'b1; e_valid = 1'b0;
    end else begin
      for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pwm_in;
      real_cnt++;
      if (DG) begin
        if (hist[3] == hist[4] && hist[4] == hist[5]) flvl = hist[3];
        lvl = flvl;
      end else begin
        lvl = hist[2];
      end
      m_rise = lvl & ~lprev;
      m_fall = ~lvl & lprev;
      lprev  = lvl;
      e_valid = 1'b0;
      case (mmode)
        0: if (real_cnt >= 6 && !lvl) mmode = 1;
        1: if (m_rise) begin t_rise = cyc; mmode = 2; end
        default: begin
          if (cyc - t_rise == TMO) begin
            e_lost = 1'b1; mmode = 1;
          end else if (mmode == 2 && m_fall) begin
            w = cyc - t_rise;
            if (w >= MIN_W && w <= MAX_W && w < WSAT) begin
              e_pos = w; e_valid = 1'b1; e_lost = 1'b0;
            end
            mmode = 3;
          end else if (mmode == 3 && m_rise) begin
            e_period = cyc - t_rise; t_rise = cyc; mmode = 2;
          end
        end
      endcase
    end
    #1;
    chk("pos",       int'(pos),       e_pos);
    chk("pos_valid", int'(pos_valid), int'(e_valid));
    chk("period",    int'(period),    e_period);
    chk("lost",      int'(lost),      int'(e_lost));
    if (pos_valid) begin nvalid++; last_valid_cyc = cyc; end
    if (lost && !prev_lost) lost_rise_cyc = cyc;
    prev_lost = lost;
  end

  task automatic drive(input bit v, input int n);
    pwm_in = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int nv0, fc, rc;

  initial begin
    rst = 1'b1; pwm_in = 1'b0; prev_lost = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("reset pos", int'(pos), 0);
    chk("reset period", int'(period), 0);
    chk("reset lost", int'(lost), 1);
    chk("reset pos_valid", int'(pos_valid), 0);
    rst = 1'b0;
    drive(0, 20);

    // Two clean frames: 180 high, 2220 low.
    nv0 = nvalid;
    drive(1, 180); fc = cyc; drive(0, 2220);
    chk("frame1 pos", int'(pos), 180);
    chk("frame1 valid count", nvalid - nv0, 1);
    chk("frame1 lost cleared", int'(lost), 0);
    chk("fall to pos_valid latency", last_valid_cyc - fc, LAT);
    drive(1, 180); drive(0, 2220);
    chk("frame2 period", int'(period), 2400);
    chk("frame2 valid count", nvalid - nv0, 2);

    // Reset released mid-pulse: that pulse must be ignored.
    drive(1, 50);
    rst = 1'b1; drive(1, 5); rst = 1'b0;
    nv0 = nvalid;
    drive(1, 100); drive(0, 200);
    chk("midpulse no valid", nvalid - nv0, 0);
    chk("midpulse pos", int'(pos), 0);
    drive(1, 120); drive(0, 300);
    chk("after midpulse pos", int'(pos), 120);
    chk("after midpulse valid count", nvalid - nv0, 1);

    // Width limits.
    nv0 = nvalid;
    drive(1, 59); drive(0, 500);
    chk("short pulse pos held", int'(pos), 120);
    chk("short pulse period", int'(period), 420);
    drive(1, 1001); drive(0, 500);
    chk("long pulse pos held", int'(pos), 120);
    chk("long pulse period", int'(period), 559);
    chk("rejects no valid", nvalid - nv0, 0);
    drive(1, 60); drive(0, 500);
    chk("min width accepted", int'(pos), 60);
    chk("min width period", int'(period), 1501);
    rc = cyc;
    drive(1, 1000); drive(0, 500);
    chk("max width accepted", int'(pos), 1000);

    // Loss of signal and recovery.
    drive(0, 4000);
    chk("timeout lost", int'(lost), 1);
    chk("timeout cycle", lost_rise_cyc - rc, LAT + TMO);
    chk("timeout pos held", int'(pos), 1000);
    drive(1, 150); drive(0, 300);
    chk("recover lost", int'(lost), 0);
    chk("recover pos", int'(pos), 150);
    chk("recover period held", int'(period), 560);

    // Two-cycle low glitch inside a 180-cycle pulse.
    nv0 = nvalid;
    drive(1, 90); drive(0, 2); drive(1, 88); drive(0, 500);
    chk("glitch pos", int'(pos), DG ? 180 : 88);
    chk("glitch valid count", nvalid - nv0, DG ? 1 : 2);

    // Input stuck high: never a valid pulse, lost at TMO.
    nv0 = nvalid;
    rc = cyc;
    drive(1, 5000);
    chk("stuck high no valid", nvalid - nv0, 0);
    chk("stuck high lost", int'(lost), 1);
    chk("stuck high timeout cycle", lost_rise_cyc - rc, LAT + TMO);
    chk("stuck high pos held", int'(pos), DG ? 180 : 88);
    drive(0, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
